// File: rtl/wb_dbg_master.sv
// rtl/wb_dbg_master.sv - byte-stream command parser driving single-beat local-bus reads/writes
// Optional bus timeout is enabled by defining WB_DBG_TIMEOUT_EN.
module wb_dbg_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_wmsk,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic        wb_ack,
  input  logic [31:0] wb_rdata
);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  data_cnt;
  logic [2:0]  rsp_cnt;
  logic [31:0] rsp_shift;
  logic        cmd_fire;
  logic        rsp_fire;
  logic        rsp_last;
  logic        bus_tmo;
  logic        bus_done;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_dbg_master: TIMEOUT must be in 1..65535");
  end

  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;
  // Status byte is reply byte 0; reads add four data bytes.
  assign rsp_last = (rsp_cnt == (wb_we ? 3'd0 : 3'd4));
  assign bus_done = (state == S_BUS) && (wb_ack || bus_tmo);

`ifdef WB_DBG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_BUS) begin
      tmo_cnt <= '0;
    end else if (!wb_ack) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Ack in the final cycle takes priority over the timeout.
  assign bus_tmo = (state == S_BUS) && !wb_ack && (tmo_cnt == TMO_LAST);
`else
  assign bus_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CMD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wb_cyc    = 1'b0;
    case (state)
      S_CMD: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = wb_we ? S_DATA : S_BUS;
      end
      S_DATA: begin
        cmd_ready = 1'b1;
        if (cmd_valid && data_cnt == 2'd3) state_nxt = S_BUS;
      end
      S_BUS: begin
        wb_cyc = 1'b1;
        if (wb_ack || bus_tmo) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_fire && rsp_last) state_nxt = S_CMD;
      end
      default: state_nxt = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr   <= '0;
      wb_wdata  <= '0;
      wb_wmsk   <= '0;
      wb_we     <= 1'b0;
      data_cnt  <= '0;
      rsp_cnt   <= '0;
      rsp_shift <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (cmd_fire) begin
        case (state)
          S_CMD: begin
            wb_we    <= cmd_data[7];
            wb_wmsk  <= cmd_data[7] ? cmd_data[3:0] : 4'h0;
            wb_wdata <= '0;
            data_cnt <= '0;
          end
          S_ADDR_HI: wb_addr[15:8] <= cmd_data;
          S_ADDR_LO: wb_addr[7:0]  <= cmd_data;
          S_DATA: begin
            wb_wdata <= {wb_wdata[23:0], cmd_data};
            data_cnt <= data_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (bus_done) begin
        rsp_valid <= 1'b1;
        rsp_cnt   <= '0;
        rsp_data  <= wb_ack ? 8'h00 : 8'hFF;
        rsp_shift <= wb_ack ? wb_rdata : 32'h0;
      end else if (rsp_fire) begin
        rsp_cnt <= rsp_cnt + 3'd1;
        if (rsp_last) begin
          rsp_valid <= 1'b0;
        end else begin
          rsp_data  <= rsp_shift[31:24];
          rsp_shift <= {rsp_shift[23:0], 8'h00};
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_dbg_master.sv
// tb/tb_wb_dbg_master.sv - self-checking bench for wb_dbg_master
// Timeout scenarios run only when WB_DBG_TIMEOUT_EN is defined.
module tb_wb_dbg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_wmsk;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic [31:0] wb_rdata;

  always #5 clk = ~clk;

  wb_dbg_master #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_wmsk   (wb_wmsk),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_ack    (wb_ack),
    .wb_rdata  (wb_rdata)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [3:0]  wmsk;
    logic [31:0] wdata;
    int          lat;
  } bus_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [3:0]  exp_wmsk;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bus_t exp_q[$];
  logic [31:0] per_mem [logic [15:0]];
  logic [31:0] ref_mem [logic [15:0]];
  logic [7:0]  rx [0:4];
  int          rx_n;
  int          last_cyc_len = 0;
  bit          stray = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {~a, a};
  endfunction

  function automatic logic [31:0] per_rd(input logic [15:0] a);
    return per_mem.exists(a) ? per_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Peripheral: checks every bus cycle against the queued expectation, acks after 'lat' cycles.
  initial begin : responder
    int   cyc_n;
    int   idle_n;
    bus_t cur;
    cyc_n = 0;
    idle_n = 100;
    cur = '{addr: 16'h0, we: 1'b0, wmsk: 4'h0, wdata: 32'h0, lat: -1};
    wb_ack = 1'b0;
    wb_rdata = 32'h0;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0;
      wb_rdata = 32'h0;
      if (wb_cyc === 1'b1) begin
        if (cyc_n == 0) begin
          chk("cyc_gap", 64'(idle_n >= 1), 64'(1));
          chk("cyc_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) cur = exp_q.pop_front();
        end
        chk("bus_fields", 64'({wb_addr, wb_we, wb_wmsk, wb_wdata}),
            64'({cur.addr, cur.we, cur.wmsk, cur.wdata}));
        if (cur.lat == cyc_n) begin
          wb_ack = 1'b1;
          if (wb_we) begin
            per_mem[wb_addr] = merge(per_rd(wb_addr), wb_wmsk, wb_wdata);
            wb_rdata = $urandom;
          end else begin
            wb_rdata = per_rd(wb_addr);
          end
        end
        cyc_n++;
      end else begin
        if (cyc_n > 0) begin
          last_cyc_len = cyc_n;
          idle_n = 0;
        end
        cyc_n = 0;
        idle_n++;
        if (stray) begin
          wb_ack = 1'b1;
          wb_rdata = 32'hA5A5_5A5A;
          stray = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int g;
    g = 0;
    if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = b;
    while (cmd_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("cmd_accept_bound", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d,
                            input bit gappy);
    send_byte(c, gappy);
    send_byte(a[15:8], gappy);
    send_byte(a[7:0], gappy);
    if (c[7]) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], gappy);
  endtask

  task automatic get_reply(input int nb, input bit bp, input string tag);
    int         guard;
    bit         stalled;
    logic [7:0] held;
    guard = 0;
    stalled = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 5; i++) rx[i] = 8'hxx;
    rx_n = 0;
    while (rx_n < nb && guard < 300) begin
      rsp_ready = bp ? guard[0] : 1'b1;
      chk({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'(0));
      if (rsp_valid === 1'b1) begin
        if (stalled) chk({tag, "_rsp_hold"}, 64'(rsp_data), 64'(held));
        if (rsp_ready) begin
          rx[rx_n] = rsp_data;
          rx_n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = rsp_data;
        end
      end
      @(negedge clk);
      guard++;
    end
    rsp_ready = 1'b1;
    chk({tag, "_rsp_count"}, 64'(rx_n), 64'(nb));
    chk({tag, "_rsp_end"}, 64'(rsp_valid), 64'(0));
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d,
                         input int lat, input logic [3:0] ewmsk, input logic [31:0] ewdata,
                         input bit gappy, input bit bp, input logic [7:0] est,
                         input logic [31:0] erd, input string tag);
    bus_t e;
    e.addr = a;
    e.we = c[7];
    e.wmsk = ewmsk;
    e.wdata = ewdata;
    e.lat = lat;
    exp_q.push_back(e);
    send_frame(c, a, d, gappy);
    get_reply(c[7] ? 1 : 5, bp, tag);
    chk({tag, "_status"}, 64'(rx[0]), 64'(est));
    if (!c[7]) chk({tag, "_rdata"}, 64'({rx[1], rx[2], rx[3], rx[4]}), 64'(erd));
    if (lat >= 0) chk({tag, "_cyc_len"}, 64'(last_cyc_len), 64'(lat + 1));
  endtask

  task automatic pulse_reset(input string tag);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_cyc"}, 64'(wb_cyc), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    exp_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs [0:8];
    logic        we;
    logic [7:0]  c;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] erd;
    int          lat;

    vecs[0] = '{8'h8F, 16'h0012, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{8'h00, 16'h4005, 32'h0,        3, 4'h0, 32'h0,        32'h12345678};
    vecs[2] = '{8'h83, 16'h0012, 32'h0000CAFE, 0, 4'h3, 32'h0000CAFE, 32'h0};
    vecs[3] = '{8'h00, 16'h0012, 32'h0,        0, 4'h0, 32'h0,        32'hDEADCAFE};
    vecs[4] = '{8'h7F, 16'h0012, 32'h55555555, 2, 4'h0, 32'h0,        32'hDEADCAFE};
    vecs[5] = '{8'hF5, 16'hFFFF, 32'h11223344, 0, 4'h5, 32'h11223344, 32'h0};
    vecs[6] = '{8'h00, 16'hFFFF, 32'h0,        4, 4'h0, 32'h0,        32'h0022FF44};
    vecs[7] = '{8'h80, 16'h0100, 32'hFFFFFFFF, 1, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[8] = '{8'h00, 16'h0100, 32'h0,        0, 4'h0, 32'h0,        32'hFEFF0100};
    per_mem[16'h4005] = 32'h12345678;
    ref_mem[16'h4005] = 32'h12345678;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cyc", 64'(wb_cyc), 64'(0));
    chk("rst_we", 64'(wb_we), 64'(0));
    chk("rst_addr", 64'(wb_addr), 64'(0));
    chk("rst_wdata", 64'(wb_wdata), 64'(0));
    chk("rst_wmsk", 64'(wb_wmsk), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

    stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("stray_ack_cyc", 64'(wb_cyc), 64'(0));
    chk("stray_ack_cmd_ready", 64'(cmd_ready), 64'(1));

    foreach (vecs[i]) begin
      run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].exp_wmsk,
              vecs[i].exp_wdata, 1'b0, 1'b0, 8'h00, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      if (vecs[i].cmd[7])
        ref_mem[vecs[i].addr] = merge(ref_rd(vecs[i].addr), vecs[i].cmd[3:0], vecs[i].wdata);
    end

    run_txn(8'h00, 16'h4005, 32'h0, 2, 4'h0, 32'h0, 1'b1, 1'b1, 8'h00, 32'h12345678, "bp_read");

`ifdef WB_DBG_TIMEOUT_EN
    run_txn(8'h00, 16'h0012, 32'h0, -1, 4'h0, 32'h0, 1'b0, 1'b0, 8'hFF, 32'h0, "tmo_noack");
    chk("tmo_noack_cyc_len", 64'(last_cyc_len), 64'(16));
    run_txn(8'h00, 16'h0012, 32'h0, 15, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, ref_rd(16'h0012),
            "tmo_ack_last");
`else
    run_txn(8'h00, 16'h0012, 32'h0, 40, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, ref_rd(16'h0012),
            "slow_ack");
`endif

    // Reset while write data is arriving, then a full write and readback.
    send_byte(8'h8F, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    pulse_reset("rst_data");
    run_txn(8'h8F, 16'h0200, 32'hA1B2C3D4, 1, 4'hF, 32'hA1B2C3D4, 1'b0, 1'b0, 8'h00, 32'h0,
            "post_rst_data_wr");
    ref_mem[16'h0200] = 32'hA1B2C3D4;
    run_txn(8'h00, 16'h0200, 32'h0, 0, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, 32'hA1B2C3D4,
            "post_rst_data_rd");
    chk("rst_data_addr_untouched", 64'(per_rd(16'h0300)), 64'(dflt(16'h0300)));

    // Reset while a bus cycle is waiting on ack.
    exp_q.push_back('{addr: 16'h0201, we: 1'b0, wmsk: 4'h0, wdata: 32'h0, lat: 1000});
    send_frame(8'h00, 16'h0201, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_bus_cyc_before", 64'(wb_cyc), 64'(1));
    pulse_reset("rst_bus");
    run_txn(8'h8C, 16'h0201, 32'h01020304, 2, 4'hC, 32'h01020304, 1'b0, 1'b0, 8'h00, 32'h0,
            "post_rst_bus_wr");
    ref_mem[16'h0201] = merge(ref_rd(16'h0201), 4'hC, 32'h01020304);
    run_txn(8'h00, 16'h0201, 32'h0, 1, 4'h0, 32'h0, 1'b0, 1'b0, 8'h00, ref_rd(16'h0201),
            "post_rst_bus_rd");

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      c = {we, 7'($urandom)};
      a = 16'h2000 + 16'($urandom_range(0, 7));
      d = $urandom;
      lat = $urandom_range(0, 6);
      erd = ref_rd(a);
      run_txn(c, a, d, lat, we ? c[3:0] : 4'h0, we ? d : 32'h0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'h00, erd, $sformatf("rand%0d", n));
      if (we) ref_mem[a] = merge(erd, c[3:0], d);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dbg_master.md
# wb_dbg_master

Byte-stream-driven initiator for the local bus that the wishbone splitter fans out to the peripherals (USB, MIDI UART, audio, video, RAM). It parses commands from an 8-bit valid/ready byte stream, for example fed by a host UART. For each command it runs one single-beat local-bus read or write and returns a status/data reply on an outgoing byte stream. It is the initiator end of the local bus and is used for bring-up and debug access without the management core.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles `wb_cyc` may stay high without `wb_ack`; range 1..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_data`  in  8  incoming command byte.
- `cmd_valid`  in  1  `cmd_data` valid.
- `cmd_ready`  out  1  block accepts the byte; a byte transfers on any edge where `cmd_valid & cmd_ready`.
- `rsp_data`  out  8  outgoing reply byte.
- `rsp_valid`  out  1  `rsp_data` valid.
- `rsp_ready`  in  1  consumer accepts; a byte transfers on any edge where `rsp_valid & rsp_ready`.
- `wb_addr`  out  16  word address.
- `wb_wdata`  out  32  write data.
- `wb_wmsk`  out  4  byte enables, 1 = byte written.
- `wb_we`  out  1  1 = write.
- `wb_cyc`  out  1  cycle request; held until ack.
- `wb_ack`  in  1  single-cycle acknowledge.
- `wb_rdata`  in  32  read data; valid only in the `wb_ack` cycle, zero otherwise.

## Operation
- Command frame:
  - Byte 0 is the command byte:
    - bit7 = write.
    - bits[6:4] are reserved and ignored.
    - bits[3:0] = byte mask, write only.
  - Bytes 1–2 are the address, MSB first.
  - Writes append 4 data bytes, MSB first (first byte → `wb_wdata[31:24]`).
- Reply format:
  - Write: 1 status byte.
  - Read: status byte, then 4 data bytes, MSB first.
  - Status is 0x00 for OK and 0xFF for timeout.
- FSM states:
  - CMD: accept byte 0 and latch `we`/mask. Go to ADDR_HI.
  - ADDR_HI: accept a byte → `wb_addr[15:8]`. Go to ADDR_LO.
  - ADDR_LO: accept a byte → `wb_addr[7:0]`. Go to BUS if read, DATA if write.
  - DATA: 2-bit byte counter 0..3, shifting into `wb_wdata`. Go to BUS after count 3.
  - BUS: `wb_cyc`=1. On `wb_ack`, capture `wb_rdata` into the 32-bit reply shift register, then go to RESP.
  - RESP: emit status, then (reads only) 4 data bytes. A 3-bit reply counter runs to 1 (write) or 5 (read). Go to CMD after the last byte transfers.
- `cmd_ready` = 1 only in CMD, ADDR_HI, ADDR_LO and DATA, decoded from state.
- `wb_we` = latched bit7. `wb_wmsk` = latched mask for writes, 4'h0 for reads.
- `wb_addr`, `wb_wdata`, `wb_we` and `wb_wmsk` are stable for the whole time `wb_cyc` is high.
- `wb_wdata` is 32'h0 for reads.
- Reply register: `rsp_data`/`rsp_valid` hold stable while `rsp_valid & ~rsp_ready`, with no byte dropped or duplicated.
- Reset mid-operation:
  - FSM returns to CMD.
  - `wb_cyc` drops on the reset edge.
  - A partial frame is discarded.
  - A pending reply is discarded.

## Timing
- Reset values:
  - `wb_cyc`, `wb_we` = 0.
  - `wb_addr`, `wb_wdata`, `wb_wmsk` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0.
  - `cmd_ready` = 1 (CMD state).
- `wb_cyc` rises on the edge that accepts the last frame byte, i.e. it is visible the next cycle.
- `wb_ack` is sampled at edge N:
  - `wb_cyc` is 0 after edge N, so a peripheral never sees `cyc` high in the cycle after its ack.
  - `rsp_valid` = 1 with the status byte after edge N.
- With `rsp_ready` held at 1, reply bytes go out on consecutive cycles.
- With `cmd_valid` held at 1, frame bytes are consumed one per cycle.
- Minimum write turnaround at a 1-cycle ack, from the last command byte to the next CMD:
  - last byte accepted → `cyc` cycle → ack cycle → status cycle → CMD.
- `wb_ack` outside BUS is ignored.

## Configuration
- `WB_DBG_TIMEOUT_EN` defined:
  - A 16-bit counter clears when `wb_cyc` rises and increments each BUS cycle without ack.
  - When the counter reaches `TIMEOUT`, `wb_cyc` drops and the status is 0xFF.
  - Read data bytes on timeout are 0x00.
  - If ack arrives in the same cycle the counter reaches `TIMEOUT`, ack wins and the status is 0x00.
- Not defined:
  - No counter is built and `TIMEOUT` is unused.
  - BUS waits indefinitely.
  - Status is always 0x00.

## Test plan
- Write: bytes 0x8F,0x00,0x12,0xDE,0xAD,0xBE,0xEF with a 1-cycle ack → `wb_addr`=0x0012, `wb_wdata`=0xDEADBEEF, `wb_wmsk`=0xF, `wb_we`=1, `wb_cyc` high exactly until ack, reply 0x00.
- Read: 0x00,0x40,0x05 with ack after 3 cycles and `wb_rdata`=0x12345678 in the ack cycle → `wb_we`=0, `wb_wmsk`=0, reply 0x00,0x12,0x34,0x56,0x78.
- Backpressure: read reply with `rsp_ready` toggling 1/0 and `cmd_valid` gappy → identical 5-byte reply, `rsp_data` stable while stalled, `cmd_ready`=0 until the reply completes.
- Timeout (macro on, `TIMEOUT`=16): read with no ack → `wb_cyc` drops after 16 cycles, reply 0xFF,0x00,0x00,0x00,0x00; repeat with ack at cycle 16 → status 0x00.
- Reset mid-operation: assert `rst` during DATA, and separately during BUS → `wb_cyc`=0 and `rsp_valid`=0 after the edge; a following full write frame executes correctly.
- Back-to-back: partial-mask write 0x83 (`wb_wmsk`=0x3) immediately followed by a read of the same address with no idle cycles → both bus cycles separated by at least one `wb_cyc`=0 cycle, replies in order.
